mem_responder: RTL and testbench

Memory-side responder for the MCU32X core data bus. It answers the core's `mem_read`/`mem_write` level strobes, serves or stores 32-bit words from an internal word-addressed RAM, inserts a configurable number of wait states, and returns a one-cycle `mem_ready` completion pulse. It checks the alignment and range of each request, flags violations on `mem_error`, and sits directly opposite the core's memory port.

---
 rtl/mcu32x_mem_pkg.sv | 13 +
 rtl/mem_responder_ram.sv | 23 ++
 rtl/mem_responder.sv | 147 ++++++++++++++
 tb/tb_mem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mcu32x_mem_pkg.sv
// Shared types and constants for the MCU32X memory-side responder.
package mcu32x_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    localparam logic [31:0] MEM_ERR_DATA = 32'hDEADBEEF;
    localparam int          MEM_WAIT_W   = 4;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous word RAM; write-first, so rdata shows new data on a write.
module mem_responder_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
            rdata       <= wdata;
        end else begin
            rdata <= mem_q[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the MCU32X data bus: accepts level strobes, inserts wait
// states, commits to RAM on the edge entering RESP and pulses mem_ready once.
module mem_responder
    import mcu32x_mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        mem_error
);

    localparam logic [MEM_WAIT_W-1:0] WAIT_INIT =
        (WAIT_STATES > 0) ? MEM_WAIT_W'(WAIT_STATES - 1) : '0;

    mem_state_e            state_q, state_d;
    logic [MEM_WAIT_W-1:0] cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  is_write_q, is_write_d;
    logic                  err_q, err_d;
    logic                  mem_ready_q, mem_ready_d;
    logic                  mem_error_q, mem_error_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [31:0]           rd_hold_q, rd_hold_d;

    logic                  commit;
    logic                  in_err;
    logic                  req_write;
    logic                  req_err;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [31:0]           req_wdata;
    logic                  ram_we;
    logic [31:0]           ram_rdata;

    assign in_err = (address[1:0] != 2'b00)
                 || ((address >> (DEPTH_LOG2 + 2)) != 32'd0)
                 || (mem_read && mem_write);

    // req_* is the request being committed: live inputs when accepting with zero wait, else the latch
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        err_d      = err_q;
        commit     = 1'b0;
        req_idx    = idx_q;
        req_wdata  = wdata_q;
        req_write  = is_write_q;
        req_err    = err_q;

        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    idx_d      = address[DEPTH_LOG2+1:2];
                    wdata_d    = write_data;
                    is_write_d = mem_write && !mem_read;
                    err_d      = in_err;
                    req_idx    = address[DEPTH_LOG2+1:2];
                    req_wdata  = write_data;
                    req_write  = mem_write && !mem_read;
                    req_err    = in_err;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ram_we      = commit && req_write && !req_err;
        mem_ready_d = commit;
        mem_error_d = commit && req_err;
        rd_valid_d  = commit && !req_write && !req_err;

        rd_hold_d = rd_hold_q;
        if (rd_valid_q) begin
            rd_hold_d = ram_rdata;
        end else if (commit && !req_write && req_err) begin
            rd_hold_d = MEM_ERR_DATA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            is_write_q  <= 1'b0;
            err_q       <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_error_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_hold_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            is_write_q  <= is_write_d;
            err_q       <= err_d;
            mem_ready_q <= mem_ready_d;
            mem_error_q <= mem_error_d;
            rd_valid_q  <= rd_valid_d;
            rd_hold_q   <= rd_hold_d;
        end
    end

    mem_responder_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (req_idx),
        .wdata(req_wdata),
        .rdata(ram_rdata)
    );

    // The RAM's registered output is the load data during a valid-read RESP; otherwise the held value
    assign read_data = rd_valid_q ? ram_rdata : rd_hold_q;
    assign mem_ready = mem_ready_q;
    assign mem_error = mem_error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) against a word-array reference model.
module tb_mem_responder;

    localparam int          DEPTH   = 1024;
    localparam logic [31:0] ERR_VAL = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] address = '0, write_data = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] read_data;
    logic        mem_ready, mem_error;

    logic [31:0] address0 = '0, write_data0 = '0;
    logic        mem_read0 = 1'b0, mem_write0 = 1'b0;
    logic [31:0] read_data0;
    logic        mem_ready0, mem_error0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] model_mem [2][DEPTH];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .address(address), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .read_data(read_data),
        .mem_ready(mem_ready), .mem_error(mem_error)
    );

    mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .address(address0), .write_data(write_data0),
        .mem_read(mem_read0), .mem_write(mem_write0), .read_data(read_data0),
        .mem_ready(mem_ready0), .mem_error(mem_error0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic driveBus(input int sel, input bit rd, input bit wr,
                            input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            address = a; write_data = d; mem_read = rd; mem_write = wr;
        end else begin
            address0 = a; write_data0 = d; mem_read0 = rd; mem_write0 = wr;
        end
    endtask

    // One request from its IDLE cycle (cycle 0) to the cycle after mem_ready, checked against the model
    task automatic applyStimulus(input int sel, input bit rd, input bit wr,
                                 input logic [31:0] a, input logic [31:0] d);
        int          ws;
        int          n;
        bit          got;
        bit          err;
        logic [31:0] exp_rd;
        logic        rdy, er;
        logic [31:0] rdat;
        ws  = (sel == 0) ? 2 : 0;
        n   = 0;
        got = 1'b0;
        driveBus(sel, rd, wr, a, d);
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            rdy = (sel == 0) ? mem_ready : mem_ready0;
            er  = (sel == 0) ? mem_error : mem_error0;
            if (rdy) got = 1'b1;
            else checkOutput("error_without_ready", {31'd0, er}, 32'd0);
        end
        checkOutput("latency", got ? n : 99, ws + 1);

        err = (a % 4 != 0) || (a >= 4 * DEPTH) || (rd && wr);
        if (wr && !rd) begin
            if (!err) model_mem[sel][a / 4] = d;
            exp_rd = last_rd[sel];
        end else begin
            exp_rd = err ? ERR_VAL : model_mem[sel][a / 4];
            last_rd[sel] = exp_rd;
        end
        er   = (sel == 0) ? mem_error : mem_error0;
        rdat = (sel == 0) ? read_data : read_data0;
        checkOutput("mem_error", {31'd0, er}, {31'd0, err});
        checkOutput("read_data", rdat, exp_rd);

        @(posedge clk);
        #1;
        rdy = (sel == 0) ? mem_ready : mem_ready0;
        checkOutput("ready_single_cycle", {31'd0, rdy}, 32'd0);
        driveBus(sel, 1'b0, 1'b0, a, d);
    endtask

    initial begin
        logic [11:0] pulse_mask;
        logic [11:0] exp_mask;
        int          pulses;
        int          kind;
        int          sel;
        logic [31:0] a;

        last_rd[0] = '0;
        last_rd[1] = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", {31'd0, mem_ready}, 32'd0);
        checkOutput("reset_error", {31'd0, mem_error}, 32'd0);
        checkOutput("reset_read_data", read_data, 32'd0);
        checkOutput("reset_read_data0", read_data0, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'h12345678);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
        applyStimulus(0, 1'b0, 1'b1, 32'h11, 32'hAAAA5555);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 32'h1000, 32'h0);
        applyStimulus(0, 1'b0, 1'b1, 32'h30, 32'h0BADF00D);
        applyStimulus(0, 1'b1, 1'b1, 32'h30, 32'h11112222);
        applyStimulus(0, 1'b1, 1'b0, 32'h30, 32'h0);
        applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h5A5A0020);

        applyStimulus(1, 1'b0, 1'b1, 32'h44, 32'hFEEDBEEF);
        applyStimulus(1, 1'b1, 1'b0, 32'h44, 32'h0);
        applyStimulus(1, 1'b1, 1'b1, 32'h44, 32'h1);

        // Held read strobe: pulses expected where cycle % (WS+2) == WS+1
        pulse_mask = '0;
        pulses     = 0;
        driveBus(0, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                pulse_mask[c] = 1'b1;
                pulses++;
                checkOutput("b2b_read_data", read_data, model_mem[0][4]);
            end
            checkOutput("b2b_error", {31'd0, mem_error}, 32'd0);
        end
        @(posedge clk);
        #1;
        checkOutput("b2b_cycle12_idle", {31'd0, mem_ready}, 32'd0);
        driveBus(0, 1'b0, 1'b0, 32'h10, 32'h0);
        last_rd[0] = model_mem[0][4];
        exp_mask = '0;
        for (int c = 1; c <= 11; c++) exp_mask[c] = ((c % 4) == 3);
        checkOutput("b2b_pulse_mask", {20'd0, pulse_mask}, {20'd0, exp_mask});
        checkOutput("b2b_pulse_count", pulses, 3);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("b2b_no_extra", {31'd0, mem_ready}, 32'd0);
        end

        // Reset during WAIT of a write: outputs clear at once, RAM keeps its old word
        driveBus(0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_ready", {31'd0, mem_ready}, 32'd0);
        checkOutput("abort_error", {31'd0, mem_error}, 32'd0);
        checkOutput("abort_read_data", read_data, 32'd0);
        driveBus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1'b0, 1'b1, 32'h100 + i * 4, $urandom);
            applyStimulus(1, 1'b0, 1'b1, 32'h100 + i * 4, $urandom);
        end
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 9);
            sel  = $urandom_range(0, 1);
            a    = 32'h100 + $urandom_range(0, 15) * 4;
            case (kind)
                0, 1, 2, 3: applyStimulus(sel, 1'b0, 1'b1, a, $urandom);
                4, 5, 6:    applyStimulus(sel, 1'b1, 1'b0, a, 32'h0);
                7:          applyStimulus(sel, kind[0] ^ i[0], !(kind[0] ^ i[0]),
                                          a + $urandom_range(1, 3), $urandom);
                8:          applyStimulus(sel, i[0], !i[0],
                                          32'h1000 + ($urandom & 32'hFFFF_EFFC), $urandom);
                default:    applyStimulus(sel, 1'b1, 1'b1, a, $urandom);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
